// File: rtl/axi_pkg.sv
// Shared AXI definitions for the default slave: response codes, FSM states, default widths.
package axi_pkg;

  localparam int unsigned ID_W_DEF    = 8;
  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned LEN_W_DEF   = 4;
  localparam int unsigned ADDR_W_DEF  = 32;
  localparam int unsigned RESP_W      = 2;
  localparam int unsigned ERR_CNT_W   = 16;

  localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
  localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;
  localparam logic [RESP_W-1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_e;

endpackage

// File: rtl/axi_ds_err_log.sv
// Error logger for the default slave: first-offender address/direction, length-mismatch
// flag and a saturating count of decoded-to-nowhere transactions.
module axi_ds_err_log
  import axi_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic                 ACLK,
  input  logic                 ARESETn,
  input  logic                 aw_hs,
  input  logic                 ar_hs,
  input  logic [ADDR_W-1:0]    aw_addr,
  input  logic [ADDR_W-1:0]    ar_addr,
  input  logic                 len_mis,
  input  logic                 clr,
  output logic [ADDR_W-1:0]    err_addr,
  output logic                 err_is_wr,
  output logic                 err_lenmis,
  output logic                 err_valid,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int unsigned SUM_W = ERR_CNT_W + 1;

  logic [ERR_CNT_W-1:0] cnt_base_c;
  logic [SUM_W-1:0]     cnt_sum_c;
  logic [ERR_CNT_W-1:0] cnt_next_c;

  // Saturating counter update; a same-cycle clear restarts the count from zero
  always_comb begin
    cnt_base_c = clr ? '0 : err_cnt;
    cnt_sum_c  = SUM_W'(cnt_base_c) + SUM_W'(aw_hs) + SUM_W'(ar_hs);
    cnt_next_c = cnt_sum_c[SUM_W-1] ? '1 : cnt_sum_c[ERR_CNT_W-1:0];
  end

  // Log registers: clear first, then any handshake or mismatch in the same cycle overrides it
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      err_addr   <= '0;
      err_is_wr  <= 1'b0;
      err_lenmis <= 1'b0;
      err_valid  <= 1'b0;
      err_cnt    <= '0;
    end else begin
      if (clr) begin
        err_addr   <= '0;
        err_is_wr  <= 1'b0;
        err_lenmis <= 1'b0;
        err_valid  <= 1'b0;
        err_cnt    <= '0;
      end
      if ((aw_hs || ar_hs) && (clr || !err_valid)) begin
        err_valid <= 1'b1;
        err_is_wr <= aw_hs;
        err_addr  <= aw_hs ? aw_addr : ar_addr;
      end
      if (len_mis) begin
        err_lenmis <= 1'b1;
      end
      if (aw_hs || ar_hs) begin
        err_cnt <= cnt_next_c;
      end
    end
  end

endmodule

// File: rtl/axi_default_slave.sv
// AXI4 default slave: consumes every burst and answers with ERR_RESP.
// Optional error logging is compiled in with DEFSLV_ERRLOG_EN.
module axi_default_slave
  import axi_pkg::*;
#(
  parameter int unsigned        ID_W     = ID_W_DEF,
  parameter int unsigned        DATA_W   = DATA_W_DEF,
  parameter int unsigned        LEN_W    = LEN_W_DEF,
  parameter int unsigned        ADDR_W   = ADDR_W_DEF,
  parameter logic [RESP_W-1:0]  ERR_RESP = RESP_DECERR
) (
  input  logic                 ACLK,
  input  logic                 ARESETn,
`ifdef DEFSLV_ERRLOG_EN
  input  logic [ADDR_W-1:0]    AWADDR,
  input  logic [ADDR_W-1:0]    ARADDR,
  input  logic                 ERR_CLR,
  output logic [ADDR_W-1:0]    ERR_ADDR,
  output logic                 ERR_IS_WR,
  output logic                 ERR_LENMIS,
  output logic                 ERR_VALID,
  output logic [ERR_CNT_W-1:0] ERR_CNT,
`endif
  input  logic [ID_W-1:0]      AWID,
  input  logic [LEN_W-1:0]     AWLEN,
  input  logic                 AWVALID,
  output logic                 AWREADY,
  input  logic                 WLAST,
  input  logic                 WVALID,
  output logic                 WREADY,
  output logic [ID_W-1:0]      BID,
  output logic [RESP_W-1:0]    BRESP,
  output logic                 BVALID,
  input  logic                 BREADY,
  input  logic [ID_W-1:0]      ARID,
  input  logic [LEN_W-1:0]     ARLEN,
  input  logic                 ARVALID,
  output logic                 ARREADY,
  output logic [ID_W-1:0]      RID,
  output logic [DATA_W-1:0]    RDATA,
  output logic [RESP_W-1:0]    RRESP,
  output logic                 RLAST,
  output logic                 RVALID,
  input  logic                 RREADY
);

  localparam int unsigned WCNT_W = LEN_W + 1;
  localparam logic [WCNT_W-1:0] WCNT_MAX = '1;

  w_state_e          w_state;
  logic [ID_W-1:0]   w_id;
  logic [LEN_W-1:0]  w_len;
  logic [WCNT_W-1:0] w_cnt;
  logic [WCNT_W-1:0] w_beats_c;
  logic              w_len_mis_c;

  r_state_e          r_state;
  logic [LEN_W-1:0]  r_cnt;

  logic              aw_hs_c;
  logic              ar_hs_c;

  assign aw_hs_c = AWVALID && AWREADY;
  assign ar_hs_c = ARVALID && ARREADY;
  assign RDATA   = '0;

  // Beat count including the current beat (saturates so an overlong burst never aliases a match)
  always_comb begin
    w_beats_c   = (w_cnt == WCNT_MAX) ? w_cnt : w_cnt + WCNT_W'(1);
    w_len_mis_c = (w_state == W_DATA) && WVALID && WLAST &&
                  (w_beats_c != (WCNT_W'(w_len) + WCNT_W'(1)));
  end

  // Write channel FSM: accept AW, drain W until WLAST, return one error B
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      w_state <= W_IDLE;
      AWREADY <= 1'b1;
      WREADY  <= 1'b0;
      BVALID  <= 1'b0;
      BID     <= '0;
      BRESP   <= '0;
      w_id    <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
    end else begin
      unique case (w_state)
        W_IDLE: begin
          if (AWVALID) begin
            w_id    <= AWID;
            w_len   <= AWLEN;
            w_cnt   <= '0;
            AWREADY <= 1'b0;
            WREADY  <= 1'b1;
            w_state <= W_DATA;
          end
        end
        W_DATA: begin
          if (WVALID) begin
            w_cnt <= w_beats_c;
            if (WLAST) begin
              WREADY  <= 1'b0;
              BVALID  <= 1'b1;
              BID     <= w_id;
              BRESP   <= ERR_RESP;
              w_state <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (BREADY) begin
            BVALID  <= 1'b0;
            BID     <= '0;
            BRESP   <= '0;
            AWREADY <= 1'b1;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Read channel FSM: accept AR, stream ARLEN+1 zero beats with error response
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state <= R_IDLE;
      ARREADY <= 1'b1;
      RVALID  <= 1'b0;
      RLAST   <= 1'b0;
      RID     <= '0;
      RRESP   <= '0;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        R_IDLE: begin
          if (ARVALID) begin
            RID     <= ARID;
            r_cnt   <= ARLEN;
            RVALID  <= 1'b1;
            RRESP   <= ERR_RESP;
            RLAST   <= (ARLEN == '0);
            ARREADY <= 1'b0;
            r_state <= R_DATA;
          end
        end
        R_DATA: begin
          if (RREADY) begin
            if (r_cnt == '0) begin
              RVALID  <= 1'b0;
              RLAST   <= 1'b0;
              RID     <= '0;
              RRESP   <= '0;
              ARREADY <= 1'b1;
              r_state <= R_IDLE;
            end else begin
              r_cnt <= r_cnt - LEN_W'(1);
              RLAST <= (r_cnt == LEN_W'(1));
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

`ifdef DEFSLV_ERRLOG_EN
  // Error logger sees both address handshakes and the write length check
  axi_ds_err_log #(
    .ADDR_W (ADDR_W)
  ) u_err_log (
    .ACLK       (ACLK),
    .ARESETn    (ARESETn),
    .aw_hs      (aw_hs_c),
    .ar_hs      (ar_hs_c),
    .aw_addr    (AWADDR),
    .ar_addr    (ARADDR),
    .len_mis    (w_len_mis_c),
    .clr        (ERR_CLR),
    .err_addr   (ERR_ADDR),
    .err_is_wr  (ERR_IS_WR),
    .err_lenmis (ERR_LENMIS),
    .err_valid  (ERR_VALID),
    .err_cnt    (ERR_CNT)
  );
`else
  // Length check and address width only feed the logger
  logic unused_cfg;
  assign unused_cfg = ^{w_len_mis_c, aw_hs_c, ar_hs_c, 32'(ADDR_W)};
`endif

endmodule

// File: tb/tb_axi_default_slave.sv
// Self-checking bench for axi_default_slave: directed cases plus randomized bursts,
// checked against transaction-level expectations of the AXI default-slave behaviour.
module tb_axi_default_slave;

  localparam int unsigned ID_W   = 8;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LEN_W  = 4;
  localparam int unsigned ADDR_W = 32;
  localparam logic [1:0]  ERR    = 2'b11;

  logic              ACLK = 1'b0;
  logic              ARESETn = 1'b0;
  logic [ID_W-1:0]   AWID = '0;
  logic [LEN_W-1:0]  AWLEN = '0;
  logic              AWVALID = 1'b0;
  logic              AWREADY;
  logic              WLAST = 1'b0;
  logic              WVALID = 1'b0;
  logic              WREADY;
  logic [ID_W-1:0]   BID;
  logic [1:0]        BRESP;
  logic              BVALID;
  logic              BREADY = 1'b0;
  logic [ID_W-1:0]   ARID = '0;
  logic [LEN_W-1:0]  ARLEN = '0;
  logic              ARVALID = 1'b0;
  logic              ARREADY;
  logic [ID_W-1:0]   RID;
  logic [DATA_W-1:0] RDATA;
  logic [1:0]        RRESP;
  logic              RLAST;
  logic              RVALID;
  logic              RREADY = 1'b0;
`ifdef DEFSLV_ERRLOG_EN
  logic [ADDR_W-1:0] AWADDR = '0;
  logic [ADDR_W-1:0] ARADDR = '0;
  logic              ERR_CLR = 1'b0;
  logic [ADDR_W-1:0] ERR_ADDR;
  logic              ERR_IS_WR;
  logic              ERR_LENMIS;
  logic              ERR_VALID;
  logic [15:0]       ERR_CNT;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 ACLK = ~ACLK;

  axi_default_slave #(
    .ID_W (ID_W), .DATA_W (DATA_W), .LEN_W (LEN_W), .ADDR_W (ADDR_W), .ERR_RESP (ERR)
  ) dut (
    .ACLK (ACLK), .ARESETn (ARESETn),
`ifdef DEFSLV_ERRLOG_EN
    .AWADDR (AWADDR), .ARADDR (ARADDR), .ERR_CLR (ERR_CLR),
    .ERR_ADDR (ERR_ADDR), .ERR_IS_WR (ERR_IS_WR), .ERR_LENMIS (ERR_LENMIS),
    .ERR_VALID (ERR_VALID), .ERR_CNT (ERR_CNT),
`endif
    .AWID (AWID), .AWLEN (AWLEN), .AWVALID (AWVALID), .AWREADY (AWREADY),
    .WLAST (WLAST), .WVALID (WVALID), .WREADY (WREADY),
    .BID (BID), .BRESP (BRESP), .BVALID (BVALID), .BREADY (BREADY),
    .ARID (ARID), .ARLEN (ARLEN), .ARVALID (ARVALID), .ARREADY (ARREADY),
    .RID (RID), .RDATA (RDATA), .RRESP (RRESP), .RLAST (RLAST), .RVALID (RVALID),
    .RREADY (RREADY)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One write burst of nbeats data beats against a burst announced as len+1; called at a negedge
  task automatic do_write(input logic [ID_W-1:0] id, input logic [LEN_W-1:0] len,
                          input int nbeats, input int bdelay, input bit wstall);
    int guard = 0;
    AWID = id; AWLEN = len; AWVALID = 1'b1;
    while (AWREADY !== 1'b1 && guard < 50) begin
      @(negedge ACLK);
      guard++;
    end
    check("aw_ready", 64'(AWREADY), 64'd1);
    @(negedge ACLK);
    AWVALID = 1'b0; AWID = '0; AWLEN = '0;
    check("w_ready_rise", 64'(WREADY), 64'd1);
    check("aw_ready_busy", 64'(AWREADY), 64'd0);
    for (int b = 0; b < nbeats; b++) begin
      if (wstall && $urandom_range(0, 1) == 1) begin
        WVALID = 1'b0;
        @(negedge ACLK);
        check("w_ready_stall", 64'(WREADY), 64'd1);
      end
      WVALID = 1'b1;
      WLAST  = (b == nbeats - 1);
      @(negedge ACLK);
      WVALID = 1'b0;
      WLAST  = 1'b0;
      if (b < nbeats - 1) begin
        check("w_ready_hold", 64'(WREADY), 64'd1);
        check("b_valid_early", 64'(BVALID), 64'd0);
      end
    end
    check("b_valid", 64'(BVALID), 64'd1);
    check("b_id", 64'(BID), 64'(id));
    check("b_resp", 64'(BRESP), 64'(ERR));
    check("w_ready_fall", 64'(WREADY), 64'd0);
    for (int d = 0; d < bdelay; d++) begin
      @(negedge ACLK);
      check("b_valid_hold", 64'(BVALID), 64'd1);
      check("b_id_hold", 64'(BID), 64'(id));
    end
    BREADY = 1'b1;
    @(negedge ACLK);
    BREADY = 1'b0;
    check("b_valid_drop", 64'(BVALID), 64'd0);
    check("b_id_idle", 64'(BID), 64'd0);
    check("aw_ready_back", 64'(AWREADY), 64'd1);
  endtask

  // One read burst; mode 0: RREADY high, 1: toggling, 2: random; called at a negedge
  task automatic do_read(input logic [ID_W-1:0] id, input logic [LEN_W-1:0] len, input int mode);
    int guard = 0;
    int beats = 0;
    int cyc = 0;
    bit rr;
    ARID = id; ARLEN = len; ARVALID = 1'b1;
    while (ARREADY !== 1'b1 && guard < 50) begin
      @(negedge ACLK);
      guard++;
    end
    check("ar_ready", 64'(ARREADY), 64'd1);
    @(negedge ACLK);
    ARVALID = 1'b0; ARID = '0; ARLEN = '0;
    while (beats <= int'(len) && cyc < 400) begin
      check("r_valid", 64'(RVALID), 64'd1);
      check("r_id", 64'(RID), 64'(id));
      check("r_data", 64'(RDATA), 64'd0);
      check("r_resp", 64'(RRESP), 64'(ERR));
      check("r_last", 64'(RLAST), 64'(beats == int'(len)));
      check("ar_ready_busy", 64'(ARREADY), 64'd0);
      case (mode)
        0:       rr = 1'b1;
        1:       rr = (cyc % 2 == 0);
        default: rr = 1'($urandom_range(0, 1));
      endcase
      RREADY = rr;
      @(negedge ACLK);
      if (rr) beats++;
      cyc++;
    end
    RREADY = 1'b0;
    check("r_beats", 64'(beats), 64'(int'(len) + 1));
    check("r_valid_drop", 64'(RVALID), 64'd0);
    check("r_last_idle", 64'(RLAST), 64'd0);
    check("r_id_idle", 64'(RID), 64'd0);
    check("ar_ready_back", 64'(ARREADY), 64'd1);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_awready"}, 64'(AWREADY), 64'd1);
    check({tag, "_arready"}, 64'(ARREADY), 64'd1);
    check({tag, "_wready"},  64'(WREADY),  64'd0);
    check({tag, "_bvalid"},  64'(BVALID),  64'd0);
    check({tag, "_rvalid"},  64'(RVALID),  64'd0);
    check({tag, "_rlast"},   64'(RLAST),   64'd0);
    check({tag, "_bresp"},   64'(BRESP),   64'd0);
    check({tag, "_rresp"},   64'(RRESP),   64'd0);
    check({tag, "_bid"},     64'(BID),     64'd0);
    check({tag, "_rid"},     64'(RID),     64'd0);
    check({tag, "_rdata"},   64'(RDATA),   64'd0);
  endtask

  initial begin
    logic [LEN_W-1:0] wl, rl;
    int nb;
    repeat (2) @(negedge ACLK);
    check_idle("reset");
    ARESETn = 1'b1;
    @(negedge ACLK);
    check_idle("post_reset");

    // Single-beat write, then a 4-beat read
    do_write(8'h3A, 4'd0, 1, 0, 1'b0);
    do_read(8'h05, 4'd3, 0);
    // Full 16-beat read with RREADY toggling
    do_read(8'hC3, 4'd15, 1);
    // Simultaneous AW/AR, B held off for 5 cycles
    fork
      do_write(8'h44, 4'd1, 2, 5, 1'b0);
      do_read(8'h55, 4'd1, 0);
    join

    // Reset during beat 2 of an 8-beat read
    ARID = 8'h77; ARLEN = 4'd7; ARVALID = 1'b1;
    @(negedge ACLK);
    ARVALID = 1'b0; ARID = '0; ARLEN = '0; RREADY = 1'b1;
    @(negedge ACLK);
    check("rst_pre_rvalid", 64'(RVALID), 64'd1);
    #2 ARESETn = 1'b0;
    #1;
    check_idle("mid_reset");
    RREADY = 1'b0;
    @(negedge ACLK);
    ARESETn = 1'b1;
    @(negedge ACLK);
    do_read(8'h21, 4'd2, 0);

    // Randomized bursts, sometimes overlapping read and write
    for (int it = 0; it < 30; it++) begin
      wl = LEN_W'($urandom_range(0, 15));
      rl = LEN_W'($urandom_range(0, 15));
      nb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 17)) : int'(wl) + 1;
      if ($urandom_range(0, 1) == 1) begin
        fork
          do_write(ID_W'($urandom), wl, nb, int'($urandom_range(0, 3)), 1'b1);
          do_read(ID_W'($urandom), rl, int'($urandom_range(0, 2)));
        join
      end else begin
        do_write(ID_W'($urandom), wl, nb, int'($urandom_range(0, 3)), 1'b1);
        do_read(ID_W'($urandom), rl, int'($urandom_range(0, 2)));
      end
    end

`ifdef DEFSLV_ERRLOG_EN
    // Logger: short write to 0x4000_0000 then a read, then clear
    ERR_CLR = 1'b1;
    @(negedge ACLK);
    ERR_CLR = 1'b0;
    check("log_clr_valid", 64'(ERR_VALID), 64'd0);
    check("log_clr_cnt", 64'(ERR_CNT), 64'd0);
    AWADDR = 32'h4000_0000;
    do_write(8'h11, 4'd3, 2, 0, 1'b0);
    AWADDR = '0;
    ARADDR = 32'h8000_0010;
    do_read(8'h12, 4'd0, 0);
    ARADDR = '0;
    check("log_addr", 64'(ERR_ADDR), 64'h4000_0000);
    check("log_is_wr", 64'(ERR_IS_WR), 64'd1);
    check("log_lenmis", 64'(ERR_LENMIS), 64'd1);
    check("log_valid", 64'(ERR_VALID), 64'd1);
    check("log_cnt", 64'(ERR_CNT), 64'd2);
    ERR_CLR = 1'b1;
    @(negedge ACLK);
    ERR_CLR = 1'b0;
    check("log_clr2_addr", 64'(ERR_ADDR), 64'd0);
    check("log_clr2_is_wr", 64'(ERR_IS_WR), 64'd0);
    check("log_clr2_lenmis", 64'(ERR_LENMIS), 64'd0);
    check("log_clr2_valid", 64'(ERR_VALID), 64'd0);
    check("log_clr2_cnt", 64'(ERR_CNT), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global time bound so the run always ends
  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule
